// File: rtl/general_pack.sv
// Shared stream-processing types and helpers.
// The truncator state encoding and the beat byte-count rule live here.
package general_pack;

  typedef enum logic [1:0] {
    BETWEEN_MSG = 2'd0,
    IN_MSG      = 2'd1,
    DROP        = 2'd2
  } msg_trunc_sm_t;

  // Bytes carried by one beat: full width unless it is the eop beat.
  function automatic int unsigned bytes_of_beat(input logic eop,
                                                input int unsigned empty,
                                                input int unsigned beat_width);
    return eop ? (beat_width - empty) : beat_width;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bundle: data/empty/sop/eop with valid-rdy handshake.
// Combinational wiring only; no latency, no storage.
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16
) ();
  localparam int EW = $clog2(DATA_WIDTH_IN_BYTES);

  logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
  logic [EW-1:0]                    empty;
  logic                             sop;
  logic                             eop;
  logic                             valid;
  logic                             rdy;

  modport master (output data, empty, sop, eop, valid, input rdy);
  modport slave  (input data, empty, sop, eop, valid, output rdy);
endinterface

// File: rtl/byte_lane_mask.sv
// Per-byte keep mask: lane i is kept when i < valid_bytes.
// Purely combinational, zero latency, no flow control.
module byte_lane_mask #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16
) (
  input  logic [$clog2(DATA_WIDTH_IN_BYTES+1)-1:0] valid_bytes,
  output logic [DATA_WIDTH_IN_BYTES-1:0]           keep
);
  for (genvar i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin : g_lane
    assign keep[i] = (32'(valid_bytes) > 32'(i));
  end
endmodule

// File: rtl/avalon_msg_truncator.sv
// Cuts each message at MAX_MSG_BYTES: forced eop, recomputed empty, zeroed tail lanes, rest dropped.
// Zero-latency data path; in rdy follows out rdy except while discarding, where it is held high.
module avalon_msg_truncator
  import general_pack::*;
#(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter int unsigned MAX_MSG_BYTES       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  in_msg,
  avalon_st_if.master out_msg,
  output logic        truncated,
  output logic [15:0] trunc_count
);
  localparam int unsigned W  = DATA_WIDTH_IN_BYTES;
  localparam int          CW = $clog2(MAX_MSG_BYTES + 1);
  localparam int          EW = $clog2(W);
  localparam int          BW = $clog2(W + 1);

  msg_trunc_sm_t   state, state_nxt;
  logic [CW-1:0]   byte_cnt, byte_cnt_nxt, cnt_base;
  int unsigned     beat_bytes, remaining;
  logic            trunc_hit, pass_state, trunc_xfer;
  logic [BW-1:0]   valid_bytes;
  logic [W-1:0]    keep;
  logic [W*8-1:0]  lane_mask;

  // A sop beat accepted in BETWEEN_MSG starts counting from zero.
  always_comb begin
    cnt_base    = (state == BETWEEN_MSG) ? '0 : byte_cnt;
    beat_bytes  = bytes_of_beat(in_msg.eop, 32'(in_msg.empty), W);
    remaining   = MAX_MSG_BYTES - 32'(cnt_base);
    trunc_hit   = (beat_bytes > remaining) || ((beat_bytes == remaining) && !in_msg.eop);
    valid_bytes = trunc_hit ? BW'(remaining) : BW'(W);
  end

  byte_lane_mask #(.DATA_WIDTH_IN_BYTES(W)) u_lane_mask (
    .valid_bytes (valid_bytes),
    .keep        (keep)
  );

  for (genvar i = 0; i < int'(W); i++) begin : g_expand
    assign lane_mask[i*8 +: 8] = {8{keep[i]}};
  end

  always_comb begin
    pass_state    = 1'b0;
    trunc_xfer    = 1'b0;
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    out_msg.valid = 1'b0;
    in_msg.rdy    = 1'b0;
    out_msg.data  = in_msg.data;
    out_msg.sop   = in_msg.sop;
    out_msg.eop   = in_msg.eop;
    out_msg.empty = in_msg.eop ? in_msg.empty : '0;

    if (!rst) begin
      unique case (state)
        BETWEEN_MSG: begin
          if (in_msg.sop) pass_state = 1'b1;
          else            in_msg.rdy = 1'b1;
        end
        IN_MSG: begin
          pass_state  = 1'b1;
          out_msg.sop = 1'b0;
        end
        DROP: begin
          in_msg.rdy = 1'b1;
          if (in_msg.valid && in_msg.eop) state_nxt = BETWEEN_MSG;
        end
        default: state_nxt = BETWEEN_MSG;
      endcase

      if (pass_state) begin
        out_msg.valid = in_msg.valid;
        in_msg.rdy    = out_msg.rdy;
        if (trunc_hit) begin
          out_msg.eop   = 1'b1;
          out_msg.empty = EW'(W - remaining);
          out_msg.data  = in_msg.data & lane_mask;
        end
        if (in_msg.valid && out_msg.rdy) begin
          if (trunc_hit) begin
            // A cut on the sop beat leaves the tail to be discarded as sop-less beats.
            trunc_xfer   = 1'b1;
            byte_cnt_nxt = '0;
            state_nxt    = (in_msg.eop || state == BETWEEN_MSG) ? BETWEEN_MSG : DROP;
          end else if (in_msg.eop) begin
            byte_cnt_nxt = '0;
            state_nxt    = BETWEEN_MSG;
          end else begin
            byte_cnt_nxt = CW'(32'(cnt_base) + beat_bytes);
            state_nxt    = IN_MSG;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BETWEEN_MSG;
      byte_cnt    <= '0;
      truncated   <= 1'b0;
      trunc_count <= '0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      truncated <= trunc_xfer;
      if (trunc_xfer && trunc_count != 16'hFFFF) trunc_count <= trunc_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_avalon_msg_truncator.sv
// Bench for avalon_msg_truncator at W=16, MAX=40 with a message-level reference model.
module tb_avalon_msg_truncator;
  localparam int W   = 16;
  localparam int MAX = 40;

  typedef struct packed {
    logic [W*8-1:0] data;
    logic           sop;
    logic           eop;
    logic [3:0]     empty;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        truncated;
  logic [15:0] trunc_count;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) in_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(W)) out_if ();

  avalon_msg_truncator #(.DATA_WIDTH_IN_BYTES(W), .MAX_MSG_BYTES(MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_msg      (in_if),
    .out_msg     (out_if),
    .truncated   (truncated),
    .trunc_count (trunc_count)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    pulses = 0;
  int    exp_pulses = 0;
  int    exp_trunc = 0;
  int    rdy_mode = 0;
  beat_t got_q[$];
  beat_t exp_q[$];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_if.rdy = 1'($urandom_range(0, 1));
      2:       out_if.rdy = 1'b0;
      default: out_if.rdy = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && out_if.valid && out_if.rdy)
      got_q.push_back({out_if.data, out_if.sop, out_if.eop, out_if.empty});
    if (truncated === 1'b1) pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  function automatic beat_t rand_beat(input bit sop, input bit eop, input logic [3:0] empty);
    beat_t b;
    b.data  = {$urandom, $urandom, $urandom, $urandom};
    b.sop   = sop;
    b.eop   = eop;
    b.empty = empty;
    return b;
  endfunction

  // Message-level model: keep the first MAX bytes of each sop-started message.
  function automatic void model(input beat_t msg[$]);
    int    cum = 0;
    int    nb;
    int    keepb;
    bit    started = 0;
    bit    done = 0;
    beat_t b;
    beat_t o;
    foreach (msg[i]) begin
      b = msg[i];
      if (done) continue;
      if (!started) begin
        if (!b.sop) continue;
        started = 1;
      end else begin
        b.sop = 1'b0;
      end
      nb = b.eop ? W - int'(b.empty) : W;
      o  = b;
      if (!b.eop) o.empty = 4'd0;
      if (cum + nb > MAX || (cum + nb == MAX && !b.eop)) begin
        keepb   = MAX - cum;
        o.eop   = 1'b1;
        o.empty = 4'(W - keepb);
        for (int j = keepb; j < W; j++) o.data[j*8 +: 8] = 8'h00;
        exp_trunc++;
        exp_pulses++;
        done = 1;
      end else begin
        cum += nb;
        if (b.eop) done = 1;
      end
      exp_q.push_back(o);
    end
  endfunction

  task automatic make_msg(input int n, input logic [3:0] last_empty, output beat_t m[$]);
    m = {};
    for (int i = 0; i < n; i++)
      m.push_back(rand_beat(i == 0, i == n - 1, (i == n - 1) ? last_empty : 4'($urandom)));
  endtask

  task automatic send_beat(input beat_t b);
    bit ok = 0;
    in_if.data  = b.data;
    in_if.sop   = b.sop;
    in_if.eop   = b.eop;
    in_if.empty = b.empty;
    in_if.valid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (in_if.rdy === 1'b1) ok = 1;
      @(posedge clk);
      #1;
    end
    in_if.valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout beat not accepted within 200 cycles, required acceptance");
    end
  endtask

  task automatic send_msg(input beat_t m[$]);
    foreach (m[i]) send_beat(m[i]);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_if.valid = 1'b1;
    in_if.sop = 1'b1;
    in_if.eop = 1'b1;
    in_if.empty = 4'd0;
    in_if.data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_if.valid); end
    total++; if (in_if.rdy !== 1'b0) begin bad++; $display("FAIL rst_in_rdy got=%b exp=0", in_if.rdy); end
    total++; if (truncated !== 1'b0) begin bad++; $display("FAIL rst_truncated got=%b exp=0", truncated); end
    total++; if (trunc_count !== 16'd0) begin bad++; $display("FAIL rst_trunc_count got=%0d exp=0", trunc_count); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_if.valid = 1'b0;
  endtask

  task automatic test_pass_exact();
    beat_t m[$];
    make_msg(2, 4'd0, m); model(m); send_msg(m);
    make_msg(3, 4'd8, m); model(m); send_msg(m);
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL pass_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL pass_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (trunc_count !== 16'(exp_trunc)) begin bad++; $display("FAIL pass_trunc_count got=%0d exp=%0d", trunc_count, exp_trunc); end
    total++; if (pulses != exp_pulses) begin bad++; $display("FAIL pass_pulses got=%0d exp=%0d", pulses, exp_pulses); end
    got_q = {}; exp_q = {};
  endtask

  task automatic test_truncate_eop();
    beat_t m[$];
    make_msg(4, 4'd0, m); model(m);
    for (int i = 0; i < 3; i++) send_beat(m[i]);
    rdy_mode = 2;
    @(posedge clk);
    #1;
    in_if.data = m[3].data; in_if.sop = 1'b0; in_if.eop = 1'b1; in_if.empty = 4'd0; in_if.valid = 1'b1;
    @(negedge clk);
    total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL drop_out_valid got=%b exp=0", out_if.valid); end
    total++; if (in_if.rdy !== 1'b1) begin bad++; $display("FAIL drop_in_rdy got=%b exp=1", in_if.rdy); end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    rdy_mode = 0;
    drain();
    total++;
    if (got_q.size() != 3) begin bad++; $display("FAIL trunc_count_beats got=%0d exp=3", got_q.size()); end
    else begin
      total++; if (got_q[2].empty !== 4'd8 || got_q[2].eop !== 1'b1) begin bad++; $display("FAIL trunc_beat3_eop_empty got=%b/%0d exp=1/8", got_q[2].eop, got_q[2].empty); end
      foreach (exp_q[i]) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL trunc_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
    total++; if (trunc_count !== 16'(exp_trunc)) begin bad++; $display("FAIL trunc_trunc_count got=%0d exp=%0d", trunc_count, exp_trunc); end
    total++; if (pulses != exp_pulses) begin bad++; $display("FAIL trunc_pulses got=%0d exp=%0d", pulses, exp_pulses); end
    got_q = {}; exp_q = {};
  endtask

  task automatic test_trunc_boundary();
    beat_t m[$];
    make_msg(4, 4'($urandom_range(0, 15)), m); model(m); send_msg(m);
    make_msg(5, 4'd3, m); model(m); send_msg(m);
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bound_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bound_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (trunc_count !== 16'(exp_trunc)) begin bad++; $display("FAIL bound_trunc_count got=%0d exp=%0d", trunc_count, exp_trunc); end
    got_q = {}; exp_q = {};
  endtask

  task automatic test_backpressure();
    beat_t m[$];
    rdy_mode = 1;
    for (int k = 0; k < 4; k++) begin
      make_msg(4, 4'd0, m); model(m); send_msg(m);
    end
    rdy_mode = 0;
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (trunc_count !== 16'(exp_trunc)) begin bad++; $display("FAIL bp_trunc_count got=%0d exp=%0d", trunc_count, exp_trunc); end
    total++; if (pulses != exp_pulses) begin bad++; $display("FAIL bp_pulses got=%0d exp=%0d", pulses, exp_pulses); end
    got_q = {}; exp_q = {};
  endtask

  task automatic test_reset_in_drop();
    beat_t m[$];
    beat_t t[$];
    make_msg(5, 4'd0, m);
    void'(m.pop_back());
    model(m); send_msg(m);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_trunc = 0;
    t = {rand_beat(0, 1, 4'd3)};
    model(t); send_msg(t);
    t = {rand_beat(1, 1, 4'd4)};
    model(t); send_msg(t);
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rstdrop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstdrop_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (got_q[got_q.size()-1].empty !== 4'd4) begin bad++; $display("FAIL rstdrop_new_empty got=%0d exp=4", got_q[got_q.size()-1].empty); end
    end
    total++; if (trunc_count !== 16'(exp_trunc)) begin bad++; $display("FAIL rstdrop_trunc_count got=%0d exp=%0d", trunc_count, exp_trunc); end
    got_q = {}; exp_q = {};
  endtask

  task automatic test_back_to_back();
    beat_t m[$];
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) begin
      make_msg($urandom_range(1, 6), 4'($urandom_range(0, 15)), m);
      if ($urandom_range(0, 3) == 0) m.push_front(rand_beat(0, 1'($urandom_range(0, 1)), 4'($urandom)));
      model(m); send_msg(m);
    end
    rdy_mode = 0;
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (trunc_count !== 16'(exp_trunc)) begin bad++; $display("FAIL b2b_trunc_count got=%0d exp=%0d", trunc_count, exp_trunc); end
    total++; if (pulses != exp_pulses) begin bad++; $display("FAIL b2b_pulses got=%0d exp=%0d", pulses, exp_pulses); end
    got_q = {}; exp_q = {};
  endtask

  initial begin
    rst = 1'b1;
    in_if.valid = 1'b0;
    in_if.sop = 1'b0;
    in_if.eop = 1'b0;
    in_if.empty = 4'd0;
    in_if.data = '0;
    test_reset();
    test_pass_exact();
    test_truncate_eop();
    test_trunc_boundary();
    test_backpressure();
    test_reset_in_drop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
